// File: rtl/router_pkg.sv
// Shared constants and types for the 1x3 router port controller.
// No ports; imported by the interface, the top and the timeout counter's users.
package router_pkg;

   localparam int unsigned NUM_PORTS       = 3;
   localparam int unsigned ADDR_W          = 2;
   localparam int unsigned TIMEOUT_DEFAULT = 30;

   typedef logic [ADDR_W-1:0] addr_t;

   localparam addr_t ADDR_INVALID = 2'b11;
   localparam addr_t PORT0        = 2'b00;
   localparam addr_t PORT1        = 2'b01;
   localparam addr_t PORT2        = 2'b10;

   // One-hot write enable for a destination address; the invalid address maps to no port.
   function automatic logic [NUM_PORTS-1:0] port_onehot(input addr_t addr);
      logic [NUM_PORTS-1:0] oh;
      oh = '0;
      case (addr)
         PORT0:   oh = 3'b001;
         PORT1:   oh = 3'b010;
         PORT2:   oh = 3'b100;
         default: oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/router_sync_ctrl_if.sv
// Bundle of the FSM / FIFO / destination signals handled by router_sync_ctrl.
// master modport: drives detect_add, din, we_en_reg, rd_en, fifoe, fifof.
// slave modport (the controller): drives we_en, fifofull, vld_out, srst.
interface router_sync_ctrl_if;
   import router_pkg::*;

   logic                 detect_add;
   addr_t                din;
   logic                 we_en_reg;
   logic [NUM_PORTS-1:0] rd_en;
   logic [NUM_PORTS-1:0] fifoe;
   logic [NUM_PORTS-1:0] fifof;
   logic [NUM_PORTS-1:0] we_en;
   logic                 fifofull;
   logic [NUM_PORTS-1:0] vld_out;
   logic [NUM_PORTS-1:0] srst;

   modport master (
      output detect_add, din, we_en_reg, rd_en, fifoe, fifof,
      input  we_en, fifofull, vld_out, srst
   );

   modport slave (
      input  detect_add, din, we_en_reg, rd_en, fifoe, fifof,
      output we_en, fifofull, vld_out, srst
   );

endinterface

// File: rtl/router_timeout_cnt.sv
// Read-timeout for one router output port: counts consecutive cycles where the port holds
// valid data that is not read, and emits a one-cycle registered soft reset after TIMEOUT
// such cycles.
// Ports: clk, rst (sync, active-low), vld (port has data), rd_en (destination reads),
//        srst (registered single-cycle soft-reset pulse).
// TIMEOUT legal range is 2..63.
module router_timeout_cnt #(
   parameter int unsigned TIMEOUT = 30
) (
   input  logic clk,
   input  logic rst,
   input  logic vld,
   input  logic rd_en,
   output logic srst
);

   localparam int unsigned CntW    = $clog2(TIMEOUT);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   logic [CntW-1:0] cnt_q;
   logic            srst_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q  <= '0;
         srst_q <= 1'b0;
      end else if (!vld || rd_en) begin
         cnt_q  <= '0;
         srst_q <= 1'b0;
      end else if (cnt_q == CntLast) begin
         // Restart from zero so a FIFO that stays full pulses again TIMEOUT cycles later.
         cnt_q  <= '0;
         srst_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_q + 1'b1;
         srst_q <= 1'b0;
      end
   end

   assign srst = srst_q;

endmodule

// File: rtl/router_sync_ctrl.sv
// Per-port controller between the router input FSM and the three output FIFOs.
// Latches the header destination address, steers the FSM write strobe to one FIFO,
// returns that FIFO's full flag, presents valid-out per port and runs per-port read
// timeouts that soft-reset unread FIFOs.
// Ports: clk, rst (sync, active-low), bus (router_sync_ctrl_if.slave).
module router_sync_ctrl
   import router_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input logic                 clk,
   input logic                 rst,
   router_sync_ctrl_if.slave   bus
);

   addr_t                addr_q;
   logic [NUM_PORTS-1:0] vld;
   logic [NUM_PORTS-1:0] srst;
   logic                 fifofull;

   // Address register: reset to the invalid address so nothing is written before a header.
   always_ff @(posedge clk) begin
      if (!rst) begin
         addr_q <= ADDR_INVALID;
      end else if (bus.detect_add) begin
         addr_q <= bus.din;
      end
   end

   always_comb begin
      fifofull = 1'b0;
      case (addr_q)
         PORT0:   fifofull = bus.fifof[0];
         PORT1:   fifofull = bus.fifof[1];
         PORT2:   fifofull = bus.fifof[2];
         default: fifofull = 1'b0;
      endcase
   end

   assign bus.we_en    = bus.we_en_reg ? port_onehot(addr_q) : '0;
   assign bus.fifofull = fifofull;

   assign vld         = ~bus.fifoe;
   assign bus.vld_out = vld;
   assign bus.srst    = srst;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timeout
      router_timeout_cnt #(
         .TIMEOUT (TIMEOUT)
      ) u_timeout_cnt (
         .clk   (clk),
         .rst   (rst),
         .vld   (vld[i]),
         .rd_en (bus.rd_en[i]),
         .srst  (srst[i])
      );
   end

endmodule

// File: tb/tb_router_sync_ctrl.sv
module tb_router_sync_ctrl;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   router_sync_ctrl_if bus ();

   router_sync_ctrl #(
      .TIMEOUT (30)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       rst;
      logic       det;
      logic [1:0] din;
      logic       wer;
      logic [2:0] rd_en;
      logic [2:0] fifoe;
      logic [2:0] fifof;
      logic [2:0] exp_we;
      logic       exp_ff;
      logic [2:0] exp_vld;
      logic [2:0] exp_srst;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus.detect_add = 1'b0;
      bus.din        = 2'b00;
      bus.we_en_reg  = 1'b0;
      bus.rd_en      = 3'b111;
      bus.fifoe      = 3'b111;
      bus.fifof      = 3'b000;

      //         rst   det   din    wer   rd_en   fifoe   fifof   we      ff    vld     srst
      vecs[0]  = '{1'b0, 1'b0, 2'b00, 1'b1, 3'b111, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000, 3'b000};
      vecs[1]  = '{1'b1, 1'b1, 2'b01, 1'b0, 3'b111, 3'b111, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000};
      vecs[2]  = '{1'b1, 1'b0, 2'b00, 1'b1, 3'b111, 3'b111, 3'b010, 3'b010, 1'b1, 3'b000, 3'b000};
      vecs[3]  = '{1'b1, 1'b0, 2'b00, 1'b1, 3'b111, 3'b111, 3'b101, 3'b010, 1'b0, 3'b000, 3'b000};
      vecs[4]  = '{1'b1, 1'b1, 2'b00, 1'b1, 3'b111, 3'b111, 3'b001, 3'b001, 1'b1, 3'b000, 3'b000};
      vecs[5]  = '{1'b1, 1'b0, 2'b00, 1'b1, 3'b111, 3'b111, 3'b110, 3'b001, 1'b0, 3'b000, 3'b000};
      vecs[6]  = '{1'b1, 1'b1, 2'b10, 1'b1, 3'b111, 3'b111, 3'b100, 3'b100, 1'b1, 3'b000, 3'b000};
      vecs[7]  = '{1'b1, 1'b0, 2'b00, 1'b0, 3'b111, 3'b111, 3'b100, 3'b000, 1'b1, 3'b000, 3'b000};
      vecs[8]  = '{1'b1, 1'b1, 2'b11, 1'b1, 3'b111, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000, 3'b000};
      vecs[9]  = '{1'b1, 1'b0, 2'b00, 1'b1, 3'b111, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000, 3'b000};
      vecs[10] = '{1'b1, 1'b1, 2'b01, 1'b1, 3'b111, 3'b010, 3'b010, 3'b010, 1'b1, 3'b101, 3'b000};
      vecs[11] = '{1'b1, 1'b0, 2'b00, 1'b1, 3'b111, 3'b000, 3'b010, 3'b010, 1'b1, 3'b111, 3'b000};
      vecs[12] = '{1'b0, 1'b1, 2'b01, 1'b1, 3'b111, 3'b000, 3'b111, 3'b000, 1'b0, 3'b111, 3'b000};

      tick();
      for (int i = 0; i < 13; i++) begin
         rst            = vecs[i].rst;
         bus.detect_add = vecs[i].det;
         bus.din        = vecs[i].din;
         bus.we_en_reg  = vecs[i].wer;
         bus.rd_en      = vecs[i].rd_en;
         bus.fifoe      = vecs[i].fifoe;
         bus.fifof      = vecs[i].fifof;
         tick();
         check($sformatf("vec%0d we_en", i), 32'(bus.we_en), 32'(vecs[i].exp_we));
         check($sformatf("vec%0d fifofull", i), 32'(bus.fifofull), 32'(vecs[i].exp_ff));
         check($sformatf("vec%0d vld_out", i), 32'(bus.vld_out), 32'(vecs[i].exp_vld));
         check($sformatf("vec%0d srst", i), 32'(bus.srst), 32'(vecs[i].exp_srst));
      end

      // Old address stays in effect during the detect_add cycle itself.
      rst = 1'b1;
      bus.detect_add = 1'b1;
      bus.din = 2'b01;
      bus.we_en_reg = 1'b0;
      tick();
      bus.din = 2'b10;
      bus.we_en_reg = 1'b1;
      bus.fifof = 3'b010;
      #1;
      check("pre-edge we_en", 32'(bus.we_en), 32'(3'b010));
      check("pre-edge fifofull", 32'(bus.fifofull), 32'(1'b1));
      tick();
      bus.detect_add = 1'b0;
      #1;
      check("post-edge we_en", 32'(bus.we_en), 32'(3'b100));
      check("post-edge fifofull", 32'(bus.fifofull), 32'(1'b0));

      // Timeout on port 0, repeated pulse when the FIFO stays non-empty.
      bus.we_en_reg = 1'b0;
      bus.fifoe = 3'b111;
      bus.rd_en = 3'b000;
      do_reset();
      bus.fifoe = 3'b110;
      #1;
      check("timeout vld_out", 32'(bus.vld_out), 32'(3'b001));
      for (int k = 1; k <= 65; k++) begin
         tick();
         check($sformatf("timeout srst edge%0d", k), 32'(bus.srst),
               32'((k == 30 || k == 60) ? 3'b001 : 3'b000));
      end

      // Read rescue at edge 30.
      bus.fifoe = 3'b111;
      do_reset();
      bus.fifoe = 3'b110;
      for (int k = 1; k <= 65; k++) begin
         bus.rd_en = (k == 30) ? 3'b001 : 3'b000;
         tick();
         check($sformatf("rescue srst edge%0d", k), 32'(bus.srst),
               32'((k == 60) ? 3'b001 : 3'b000));
      end
      bus.rd_en = 3'b000;

      // Reset mid-count on port 2; also confirms addr returns to invalid.
      bus.fifoe = 3'b111;
      do_reset();
      bus.detect_add = 1'b1;
      bus.din = 2'b00;
      tick();
      bus.detect_add = 1'b0;
      bus.fifoe = 3'b011;
      bus.we_en_reg = 1'b1;
      bus.fifof = 3'b001;
      for (int k = 1; k <= 55; k++) begin
         rst = (k == 20) ? 1'b0 : 1'b1;
         tick();
         check($sformatf("midrst srst edge%0d", k), 32'(bus.srst),
               32'((k == 50) ? 3'b100 : 3'b000));
         if (k == 19) check("midrst we_en before", 32'(bus.we_en), 32'(3'b001));
         if (k == 20) begin
            check("midrst we_en after", 32'(bus.we_en), 32'(3'b000));
            check("midrst fifofull after", 32'(bus.fifofull), 32'(1'b0));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
